// File: rtl/urna_apuracao_if.sv
// Tally read-out bus: vote tallies and start request in, displayed entry and status out.
interface urna_apuracao_if;
  logic       Start;
  logic [7:0] C1;
  logic [7:0] C2;
  logic [7:0] C3;
  logic [7:0] C4;
  logic [7:0] Nulo;
  logic [2:0] Sel;
  logic [3:0] Hundreds;
  logic [3:0] Tens;
  logic [3:0] Units;
  logic [2:0] Winner;
  logic       Busy;
  logic       Done;

  modport master (
    output Start, C1, C2, C3, C4, Nulo,
    input  Sel, Hundreds, Tens, Units, Winner, Busy, Done
  );

  modport slave (
    input  Start, C1, C2, C3, C4, Nulo,
    output Sel, Hundreds, Tens, Units, Winner, Busy, Done
  );
endinterface

// File: rtl/urna_apuracao.sv
// Ballot tally read-out: snapshots the tallies, picks the winner and shows each
// entry as BCD for DWELL_CYCLES cycles, converting each entry serially (double dabble).
module urna_apuracao #(
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input logic              Clock,
  input logic              Reset,
  urna_apuracao_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, SNAP, CONV, SHOW, DONE} state_t;

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 32'd1);

  state_t      state;
  logic [7:0]  snap_c1, snap_c2, snap_c3, snap_c4, snap_nulo;
  logic [2:0]  idx;
  logic [7:0]  bin_sr;
  logic [11:0] bcd_sr;
  logic [3:0]  iter;
  logic [31:0] dwell;
  logic [2:0]  sel_q, winner_q;
  logic [3:0]  hund_q, tens_q, unit_q;
  logic        busy_q, done_q;

  logic [11:0] bcd_adj;
  logic [11:0] bcd_next;
  logic [7:0]  bin_next;
  logic [7:0]  next_val;
  logic [7:0]  cand [4];
  logic [7:0]  mx;
  logic [2:0]  hits;
  logic [2:0]  win_n;

  assign bus.Sel      = sel_q;
  assign bus.Hundreds = hund_q;
  assign bus.Tens     = tens_q;
  assign bus.Units    = unit_q;
  assign bus.Winner   = winner_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

  // One double-dabble step: add 3 to any digit >= 5, then shift the next binary bit in.
  always_comb begin
    bcd_adj = bcd_sr;
    if (bcd_sr[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd_sr[3:0]  + 4'd3;
    if (bcd_sr[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd_sr[7:4]  + 4'd3;
    if (bcd_sr[11:8] >= 4'd5) bcd_adj[11:8] = bcd_sr[11:8] + 4'd3;
    bcd_next = {bcd_adj[10:0], bin_sr[7]};
    bin_next = {bin_sr[6:0], 1'b0};
  end

  // Entry following the one currently displayed.
  always_comb begin
    next_val = snap_nulo;
    case (sel_q)
      3'd0:    next_val = snap_c2;
      3'd1:    next_val = snap_c3;
      3'd2:    next_val = snap_c4;
      default: next_val = snap_nulo;
    endcase
  end

  always_comb begin
    cand[0] = snap_c1;
    cand[1] = snap_c2;
    cand[2] = snap_c3;
    cand[3] = snap_c4;
    mx      = '0;
    hits    = '0;
    win_n   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (cand[i] > mx) mx = cand[i];
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (cand[i] == mx) begin
        hits  = hits + 3'd1;
        win_n = 3'(i + 1);
      end
    end
    if (mx == '0 || hits != 3'd1) win_n = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      snap_c1   <= '0;
      snap_c2   <= '0;
      snap_c3   <= '0;
      snap_c4   <= '0;
      snap_nulo <= '0;
      idx       <= '0;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      iter      <= '0;
      dwell     <= '0;
      sel_q     <= '0;
      winner_q  <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      unit_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.Start) begin
            snap_c1   <= bus.C1;
            snap_c2   <= bus.C2;
            snap_c3   <= bus.C3;
            snap_c4   <= bus.C4;
            snap_nulo <= bus.Nulo;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            state     <= SNAP;
          end
        end
        SNAP: begin
          winner_q <= win_n;
          idx      <= '0;
          bin_sr   <= snap_c1;
          bcd_sr   <= '0;
          iter     <= '0;
          state    <= CONV;
        end
        CONV: begin
          if (iter != 4'd8) begin
            bcd_sr <= bcd_next;
            bin_sr <= bin_next;
            iter   <= iter + 4'd1;
          end else begin
            // Display registers change only here, so no partial result is ever visible.
            sel_q  <= idx;
            hund_q <= bcd_sr[11:8];
            tens_q <= bcd_sr[7:4];
            unit_q <= bcd_sr[3:0];
            dwell  <= '0;
            state  <= SHOW;
          end
        end
        SHOW: begin
          if (dwell == DWELL_LAST) begin
            if (sel_q < 3'd4) begin
              idx    <= sel_q + 3'd1;
              bin_sr <= next_val;
              bcd_sr <= '0;
              iter   <= '0;
              state  <= CONV;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end else begin
            dwell <= dwell + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
